// File: rtl/matmul_seq_ctrl_if.sv
// Bundle of the handshake and data signals between the MAC-ALU sequencer and
// its surroundings (top-level controller, input stream, X buffer, ALU,
// result RAM).
//   master : environment side (controller, input source, ALU)
//   slave  : sequencer side (matmul_seq_ctrl)
interface matmul_seq_ctrl_if #(
  parameter int RES_W  = 18,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic [63:0]       in_data;
  logic              in_ready;
  logic              buf_we;
  logic [1:0]        buf_row;
  logic [63:0]       buf_data;
  logic              alu_en;
  logic              alu_web;
  logic [RES_W-1:0]  mu1;
  logic [RES_W-1:0]  mu2;
  logic [RES_W-1:0]  mu3;
  logic [RES_W-1:0]  mu4;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [RES_W-1:0]  ram_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data, alu_web, mu1, mu2, mu3, mu4,
    input  in_ready, buf_we, buf_row, buf_data, alu_en,
           ram_we, ram_addr, ram_wdata, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data, alu_web, mu1, mu2, mu3, mu4,
    output in_ready, buf_we, buf_row, buf_data, alu_en,
           ram_we, ram_addr, ram_wdata, busy, done, err
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 4-row multiply-accumulate ALU.
// Loads a 4-row input tile into the X buffer, enables the ALU for one
// RUN_CYC-cycle pass, captures the four column sums on each ALU write strobe
// and serializes them into the result RAM (address col*4 + row).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave modport: start/in_* input stream, buf_* X buffer writes,
//          alu_en/alu_web/mu1..mu4 ALU, ram_* result RAM, busy/done/err status
module matmul_seq_ctrl #(
  parameter int RES_W     = 18,
  parameter int NUM_COLS  = 4,
  parameter int RUN_CYC   = 32,
  parameter int ADDR_W    = 4,
  parameter int DRAIN_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  matmul_seq_ctrl_if.slave  bus
);
  localparam int COL_W = $clog2(NUM_COLS + 1);
  localparam int RUN_W = $clog2(RUN_CYC);
  localparam int DRN_W = $clog2(DRAIN_MAX);
  localparam int SC_W  = ADDR_W - 2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       beat_q;
  logic [RUN_W-1:0] run_q;
  logic [COL_W-1:0] col_q;
  logic [DRN_W-1:0] drn_q;
  logic             ser_act_q;
  logic [1:0]       ser_idx_q;
  logic [SC_W-1:0]  ser_col_q;
  logic [RES_W-1:0] hold_q [4];
  logic             err_q;

  logic in_ready_s, alu_en_s, busy_s, done_s;
  logic start_ok, beat_acc, cap_win, cols_done, capture, web_bad;
  logic ser_free, timeout, timeout_exit;

  assign start_ok  = (state_q == S_IDLE) && bus.start;
  assign beat_acc  = (state_q == S_LOAD) && bus.in_valid;
  assign cap_win   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign cols_done = (col_q == COL_W'(NUM_COLS));
  // Capture needs a fully idle serializer; a strobe landing on the last word
  // of the previous sequence is a collision.
  assign capture   = bus.alu_web && cap_win && !ser_act_q && !cols_done;
  assign web_bad   = bus.alu_web && !capture;
  // DRAIN may leave while the final word is being written, so that the last
  // RAM write and the DONE cycle are back to back.
  assign ser_free  = !ser_act_q || (ser_idx_q == 2'd3);
  assign timeout   = (drn_q == DRN_W'(DRAIN_MAX - 1));
  assign timeout_exit = (state_q == S_DRAIN) && (state_d == S_DONE) && !cols_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  if (beat_acc && (beat_q == 2'd3)) state_d = S_RUN;
      S_RUN:   if (run_q == RUN_W'(RUN_CYC - 1)) state_d = S_DRAIN;
      S_DRAIN: if (ser_free && !capture && (cols_done || timeout)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready_s = 1'b0;
    alu_en_s   = 1'b0;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    unique case (state_q)
      S_IDLE:  busy_s     = 1'b0;
      S_LOAD:  in_ready_s = 1'b1;
      S_RUN:   alu_en_s   = 1'b1;
      S_DONE:  done_s     = 1'b1;
      default: ;
    endcase
  end

  // Counters, capture registers, serializer and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q    <= '0;
      run_q     <= '0;
      col_q     <= '0;
      drn_q     <= '0;
      ser_act_q <= 1'b0;
      ser_idx_q <= '0;
      ser_col_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hold_q[i] <= '0;
    end else begin
      if (start_ok) begin
        beat_q <= '0;
        run_q  <= '0;
        col_q  <= '0;
      end
      if (beat_acc) beat_q <= beat_q + 2'd1;
      if (state_q == S_RUN) run_q <= run_q + RUN_W'(1);

      if (state_q != S_DRAIN) drn_q <= '0;
      else if (!timeout)      drn_q <= drn_q + DRN_W'(1);

      if (capture) begin
        hold_q[0] <= bus.mu1;
        hold_q[1] <= bus.mu2;
        hold_q[2] <= bus.mu3;
        hold_q[3] <= bus.mu4;
        ser_act_q <= 1'b1;
        ser_idx_q <= '0;
        ser_col_q <= SC_W'(col_q);
        col_q     <= col_q + COL_W'(1);
      end else if (ser_act_q) begin
        ser_idx_q <= ser_idx_q + 2'd1;
        if (ser_idx_q == 2'd3) ser_act_q <= 1'b0;
      end

      if (start_ok)                err_q <= 1'b0;
      if (web_bad || timeout_exit) err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.alu_en    = alu_en_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.buf_we    = bus.in_valid & in_ready_s;
  assign bus.buf_row   = beat_q;
  assign bus.buf_data  = bus.in_data;
  assign bus.ram_we    = ser_act_q;
  assign bus.ram_addr  = {ser_col_q, ser_idx_q};
  assign bus.ram_wdata = hold_q[ser_idx_q];
  assign bus.err       = err_q;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: table of pass scenarios with
// hand-computed timing/results, plus hand-written reset sequences.
module tb_matmul_seq_ctrl;
  localparam int RES_W  = 18;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_seq_ctrl_if #(.RES_W(RES_W), .ADDR_W(ADDR_W)) bus();

  matmul_seq_ctrl #(
    .RES_W(RES_W), .NUM_COLS(4), .RUN_CYC(32), .ADDR_W(ADDR_W), .DRAIN_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    bit    stall;
    bit    skip3;
    bit    collide;
    bit    busy_start;
    int    exp_done;
    int    exp_en_first;
    int    exp_writes;
    int    exp_err;
  } scn_t;

  scn_t tbl [5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic scn_t mk(input string name, input bit stall, input bit skip3,
                              input bit collide, input bit busy_start, input int exp_done,
                              input int exp_en_first, input int exp_writes, input int exp_err);
    scn_t s;
    s.name = name; s.stall = stall; s.skip3 = skip3; s.collide = collide;
    s.busy_start = busy_start; s.exp_done = exp_done; s.exp_en_first = exp_en_first;
    s.exp_writes = exp_writes; s.exp_err = exp_err;
    return s;
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.alu_web = 1'b0;
    bus.mu1 = '0; bus.mu2 = '0; bus.mu3 = '0; bus.mu4 = '0;
  endtask

  task automatic strobe(input int base);
    bus.alu_web = 1'b1;
    bus.mu1 = RES_W'(base + 1);
    bus.mu2 = RES_W'(base + 2);
    bus.mu3 = RES_W'(base + 3);
    bus.mu4 = RES_W'(base + 4);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"},  bus.in_ready,  0);
    check({tag, " alu_en"},    bus.alu_en,    0);
    check({tag, " ram_we"},    bus.ram_we,    0);
    check({tag, " busy"},      bus.busy,      0);
    check({tag, " done"},      bus.done,      0);
    check({tag, " err"},       bus.err,       0);
    check({tag, " ram_addr"},  bus.ram_addr,  0);
    check({tag, " ram_wdata"}, bus.ram_wdata, 0);
    check({tag, " buf_row"},   bus.buf_row,   0);
  endtask

  // One pass: inputs driven at the falling edge, outputs sampled 1 time unit later.
  // Cycle 0 is the cycle in which start is high.
  task automatic run_scn(input scn_t s);
    int en_first = -1, en_len = 0, nbeat = 0, last_beat = -1;
    int done_cyc = -1, done_cnt = 0, err_done = -1, busy_after = -1;
    int wr_first = -1, busy1 = -1, rdy1 = -1;
    int rows [4];
    int waddr [$];
    int wdata [$];
    for (int i = 0; i < 4; i++) rows[i] = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start    = (c == 0) || (s.busy_start && c == 10);
      bus.in_valid = s.stall ? ((c % 2) == 1) : 1'b1;
      bus.in_data  = 64'h0102_0304_0506_0700 + 64'(c);
      bus.alu_web  = 1'b0;
      bus.mu1 = '0; bus.mu2 = '0; bus.mu3 = '0; bus.mu4 = '0;
      if (bus.alu_en === 1'b1 && en_first < 0) en_first = c;
      if (en_first >= 0) begin
        int d;
        d = c - en_first;
        if (d >= 8 && d <= 32 && (d % 8) == 0 && !(s.skip3 && d == 32))
          strobe((d / 8 - 1) * 16);
        if (s.collide && d == 10) strobe(990);
      end
      #1;
      if (c == 1) begin busy1 = bus.busy; rdy1 = bus.in_ready; end
      if (bus.alu_en === 1'b1) en_len++;
      if (bus.buf_we === 1'b1) begin
        if (nbeat < 4) rows[nbeat] = int'(bus.buf_row);
        nbeat++;
        last_beat = c;
      end
      if (bus.ram_we === 1'b1) begin
        if (wr_first < 0) wr_first = c;
        waddr.push_back(int'(bus.ram_addr));
        wdata.push_back(int'(bus.ram_wdata));
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        err_done = int'(bus.err);
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(bus.busy);
      if (done_cyc >= 0 && c == done_cyc + 3) break;
    end
    idle_inputs();

    check({s.name, " done cycle"},       done_cyc, s.exp_done);
    check({s.name, " done pulses"},      done_cnt, 1);
    check({s.name, " busy cycle1"},      busy1, 1);
    check({s.name, " in_ready cycle1"},  rdy1, 1);
    check({s.name, " alu_en first"},     en_first, s.exp_en_first);
    check({s.name, " alu_en length"},    en_len, 32);
    check({s.name, " beats"},            nbeat, 4);
    for (int i = 0; i < 4; i++) check({s.name, " buf_row seq"}, rows[i], i);
    check({s.name, " alu_en after beat4"}, en_first, last_beat + 1);
    check({s.name, " first write cycle"}, wr_first, s.exp_en_first + 9);
    check({s.name, " write count"},      waddr.size(), s.exp_writes);
    for (int k = 0; k < waddr.size() && k < 16; k++) begin
      check({s.name, " ram_addr"},  waddr[k], k);
      check({s.name, " ram_wdata"}, wdata[k], (k / 4) * 16 + (k % 4) + 1);
    end
    check({s.name, " err at done"},      err_done, s.exp_err);
    check({s.name, " busy after done"},  busy_after, 0);
  endtask

  initial begin
    tbl[0] = mk("nominal",         0, 0, 0, 0, 42, 5, 16, 0);
    tbl[1] = mk("stalled load",    1, 0, 0, 0, 45, 8, 16, 0);
    tbl[2] = mk("missing strobe",  0, 1, 0, 0, 45, 5, 12, 1);
    tbl[3] = mk("strobe collision",0, 0, 1, 0, 42, 5, 16, 1);
    tbl[4] = mk("start while busy",0, 0, 0, 1, 42, 5, 16, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_scn(tbl[t]);

    // Reset in cycle 20 with err set and a serializer sequence in flight.
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      idle_inputs();
      bus.start    = (c == 0);
      bus.in_valid = 1'b1;
      if (c == 13 || c == 15 || c == 19) strobe(100 + c);
      rst = (c == 20);
      #1;
      if (c == 20) begin
        check("midrst err before", bus.err, 1);
        check("midrst ram_we before", bus.ram_we, 1);
        check("midrst ram_wdata before", bus.ram_wdata, 120);
      end
      if (c == 21) check_all_zero("midrst cycle21");
    end
    rst = 1'b0;
    idle_inputs();
    run_scn(mk("after reset", 0, 0, 0, 0, 42, 5, 16, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer for the 4-row multiply-accumulate ALU. It loads one 4×8-byte input tile into the X buffer, holds the ALU enable for exactly one 32-cycle compute pass, and captures the four 18-bit column sums on each ALU write strobe. It serializes those sums into the result RAM and reports completion or protocol errors to the top-level controller.

## Interface
- `RES_W`, 18: width of each MU result and of `ram_wdata`.
- `NUM_COLS`, 4: number of ALU write strobes (output columns) per pass.
- `RUN_CYC`, 32: number of cycles `alu_en` is held high per pass.
- `ADDR_W`, 4: result RAM address width (holds NUM_COLS*4 words).
- `DRAIN_MAX`, 8: maximum number of DRAIN cycles before timeout.

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to process one tile; ignored unless in IDLE.
- `in_valid`  in  1  input row beat valid.
- `in_data`  in  64  one input row: 8 × 8-bit elements, element 0 in [63:56].
- `in_ready`  out  1  high in LOAD.
- `buf_we`  out  1  X buffer row write; equals in_valid & in_ready.
- `buf_row`  out  2  target row 0..3 for the current beat.
- `buf_data`  out  64  in_data passed through.
- `alu_en`  out  1  ALU enable.
- `alu_web`  in  1  ALU column-complete strobe; mu1..mu4 are valid in the same cycle.
- `mu1`..`mu4`  in  RES_W each  ALU column sums for rows 1..4.
- `ram_we`  out  1  result RAM write enable.
- `ram_addr`  out  ADDR_W  result RAM address, col*4 + row.
- `ram_wdata`  out  RES_W  result word.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `err`  out  1  sticky error flag; cleared by `rst` or by an accepted `start`.

## Operation
- **States:** IDLE → LOAD → RUN → DRAIN → DONE → IDLE.
- **IDLE.** When `start` is high, go to LOAD and clear `err`, the beat counter, the column counter and the run counter.
- **LOAD.** `in_ready` is 1. Each accepted beat writes row `beat_cnt` and increments `beat_cnt`. When beat 3 is accepted, go to RUN.
- **RUN.** `alu_en` is 1. `run_cnt` counts 0..RUN_CYC-1. When `run_cnt` reaches RUN_CYC-1, go to DRAIN; `alu_en` is 0 from the next cycle.
- **Capture.**
  - In RUN or DRAIN, when `alu_web` is high and the serializer is idle, latch mu1..mu4 into the holding registers. Then `col_cnt` is incremented.
  - When `alu_web` is high and the serializer is busy, drop the sample and set `err`.
  - When `alu_web` is high and `col_cnt` is already NUM_COLS, drop the sample and set `err`.
- **Serializer.** For the 4 cycles after a capture, `ram_we` is 1 with `ram_addr` = `col`*4 + i and `ram_wdata` = `mu{i+1}`, for i = 0..3. `col` is the column index latched at capture.
- **DRAIN.**
  - Exit to DONE when `col_cnt` == NUM_COLS and the serializer is idle.
  - Exit to DONE with `err` set if DRAIN_MAX cycles elapse first; in that case the serializer completes any in-progress word sequence before DONE.
- **DONE.** `done` is 1 for one cycle, then go to IDLE.
- **`alu_web` in IDLE, LOAD or DONE:** ignored and sets `err`.
- **`start` while busy:** ignored, no side effects.
- **Outputs:** all outputs except the `buf_*` pass-through signals are registered or decoded from state.

## Timing
- **Reset values:** all outputs are 0 after `rst` (`in_ready`, `alu_en`, `ram_we`, `busy`, `done`, `err`, `ram_addr`, `ram_wdata`, `buf_row`); state is IDLE.
- **Reset mid-pass:** `rst` in any state returns to IDLE in the next cycle and drops pending serializer words.
- **Start:** `start` high in cycle 0 gives `busy` and `in_ready` high from cycle 1.
- **Load:** with continuous `in_valid`, the beats land in cycles 1..4.
- **Compute:** `alu_en` is high in cycles 5..36 (exactly RUN_CYC cycles).
- **ALU strobe timing:** the ALU registers its strobe, so `alu_web` arrives at cycles 13, 21, 29 and 37. The last strobe falls in DRAIN.
- **Capture to RAM latency:** a capture at cycle t produces `ram_we` in cycles t+1..t+4.
- **Completion:** the last write is in cycle 41 and `done` is in cycle 42.
- **Serializer occupancy:** minimum `alu_web` spacing of 5 cycles is supported without error; a spacing of 4 cycles or less sets `err`.

## Test plan
- **Nominal pass:** `start` at cycle 0 with continuous `in_valid`, and the ALU model strobes at 13/21/29/37 with mu = {col*16+1, +2, +3, +4}. Required: 16 RAM writes at addresses 0..15 with matching data, `alu_en` high for exactly 32 cycles, `done` at cycle 42, `err` = 0.
- **Stalled load:** `in_valid` toggles every other cycle. Required: `buf_row` sequence 0,1,2,3; `alu_en` does not rise until the cycle after the 4th beat; RAM output is identical to the nominal pass.
- **Missing strobe:** the ALU model omits the column-3 strobe. Required: DRAIN times out after 8 cycles, `done` pulses, `err` = 1, and only addresses 0..11 are written.
- **Strobe collision:** two `alu_web` pulses 2 cycles apart. Required: the second sample is dropped, `err` = 1, and `col_cnt` is not incremented for it.
- **Reset mid-run:** `rst` asserted in cycle 20. Required: all outputs are 0 in cycle 21. A following `start` then runs a clean nominal pass with `err` = 0.
- **Start while busy:** `start` pulsed in cycle 10. Required: no effect, and the timing matches the nominal pass exactly.
